// File: rtl/intra_interp_filter_pipe.sv
// Pipelined 4-tap VVC intra angular interpolation filter (fC cubic / fG gaussian).
// Define INTERP_CLIP_EN to clip results to the sample range; otherwise they wrap.
module intra_interp_filter_pipe #(
  parameter int BIT_DEPTH = 8,
  parameter int LANES     = 4,
  parameter int ACC_W     = BIT_DEPTH + 9
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [(LANES+3)*BIT_DEPTH-1:0] in_ref,
  input  logic [4:0]                     in_phase,
  input  logic                           in_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*BIT_DEPTH-1:0]     out_pred
);

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t RND  = acc_t'(32);
  localparam acc_t MAXV = acc_t'((1 << BIT_DEPTH) - 1);

  function automatic logic [31:0] row(
    input int c0, c1, c2, c3
  );
    return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  // Coefficient-bit-steered shift-add network, sign applied last.
  function automatic acc_t shadd(
    input logic [BIT_DEPTH-1:0] x,
    input logic [7:0]           c
  );
    logic [ACC_W-1:0] acc;
    logic [7:0]       m;
    acc = '0;
    m   = c[7] ? 8'(-c) : c;
    for (int b = 0; b < 7; b++)
      if (m[b]) acc = acc + (ACC_W'(x) << b);
    return c[7] ? acc_t'(-acc) : acc_t'(acc);
  endfunction

  logic [31:0] crow;
  logic [3:0]  g;

  always_comb begin
    g    = in_phase[4:1];
    crow = '0;
    if (in_mode) begin
      crow = row(16 - int'(g), 32 - int'(g),
                 16 + int'(g), int'(g));
    end else begin
      unique case (in_phase)
        5'd0:  crow = row( 0, 64,  0,  0);
        5'd1:  crow = row(-1, 63,  2,  0);
        5'd2:  crow = row(-2, 62,  4,  0);
        5'd3:  crow = row(-2, 60,  7, -1);
        5'd4:  crow = row(-2, 58, 10, -2);
        5'd5:  crow = row(-3, 57, 12, -2);
        5'd6:  crow = row(-4, 56, 14, -2);
        5'd7:  crow = row(-4, 55, 15, -2);
        5'd8:  crow = row(-4, 54, 16, -2);
        5'd9:  crow = row(-5, 53, 18, -2);
        5'd10: crow = row(-6, 52, 20, -2);
        5'd11: crow = row(-6, 49, 24, -3);
        5'd12: crow = row(-6, 46, 28, -4);
        5'd13: crow = row(-5, 44, 29, -4);
        5'd14: crow = row(-4, 42, 30, -4);
        5'd15: crow = row(-4, 39, 33, -4);
        5'd16: crow = row(-4, 36, 36, -4);
        5'd17: crow = row(-4, 33, 39, -4);
        5'd18: crow = row(-4, 30, 42, -4);
        5'd19: crow = row(-4, 29, 44, -5);
        5'd20: crow = row(-4, 28, 46, -6);
        5'd21: crow = row(-3, 24, 49, -6);
        5'd22: crow = row(-2, 20, 52, -6);
        5'd23: crow = row(-2, 18, 53, -5);
        5'd24: crow = row(-2, 16, 54, -4);
        5'd25: crow = row(-2, 15, 55, -4);
        5'd26: crow = row(-2, 14, 56, -4);
        5'd27: crow = row(-2, 12, 57, -3);
        5'd28: crow = row(-2, 10, 58, -2);
        5'd29: crow = row(-1,  7, 60, -2);
        5'd30: crow = row( 0,  4, 62, -2);
        5'd31: crow = row( 0,  2, 63, -1);
      endcase
    end
  end

  acc_t s1_p_d   [LANES][4];
  acc_t s1_p_q   [LANES][4];
  acc_t s2_sum_d [LANES];
  acc_t s2_sum_q [LANES];

  logic [LANES*BIT_DEPTH-1:0] s3_pred_d;
  logic [LANES*BIT_DEPTH-1:0] s3_pred_q;

  logic s1_v_q, s2_v_q, s3_v_q;
  logic en;

  always_comb begin
    for (int i = 0; i < LANES; i++)
      for (int k = 0; k < 4; k++)
        s1_p_d[i][k] = shadd(
          in_ref[(i+k)*BIT_DEPTH +: BIT_DEPTH],
          crow[8*k +: 8]);
  end

  always_comb begin
    for (int i = 0; i < LANES; i++)
      s2_sum_d[i] = s1_p_q[i][0] + s1_p_q[i][1]
                  + s1_p_q[i][2] + s1_p_q[i][3];
  end

  always_comb begin : s3_comb
    acc_t r;
    r         = '0;
    s3_pred_d = '0;
    for (int i = 0; i < LANES; i++) begin
      r = (s2_sum_q[i] + RND) >>> 6;
`ifdef INTERP_CLIP_EN
      if (r < 0)
        s3_pred_d[i*BIT_DEPTH +: BIT_DEPTH] = '0;
      else if (r > MAXV)
        s3_pred_d[i*BIT_DEPTH +: BIT_DEPTH] = '1;
      else
        s3_pred_d[i*BIT_DEPTH +: BIT_DEPTH] =
          r[BIT_DEPTH-1:0];
`else
      s3_pred_d[i*BIT_DEPTH +: BIT_DEPTH] =
        r[BIT_DEPTH-1:0];
`endif
    end
  end

  assign en        = out_ready | ~s3_v_q;
  assign in_ready  = en;
  assign out_valid = s3_v_q;
  assign out_pred  = s3_pred_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s3_v_q    <= 1'b0;
      s1_p_q    <= '{default: '0};
      s2_sum_q  <= '{default: '0};
      s3_pred_q <= '0;
    end else if (en) begin
      s1_v_q    <= in_valid;
      s2_v_q    <= s1_v_q;
      s3_v_q    <= s2_v_q;
      s1_p_q    <= s1_p_d;
      s2_sum_q  <= s2_sum_d;
      s3_pred_q <= s3_pred_d;
    end
  end

endmodule

// File: tb/tb_intra_interp_filter_pipe.sv
// Directed bench for intra_interp_filter_pipe: table rows, rounding,
// range handling, latency, bubbles, backpressure and mid-stream reset.
module tb_intra_interp_filter_pipe;

  localparam int BD = 8;
  localparam int L  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_mode;
  logic              out_valid, out_ready;
  logic [4:0]        in_phase;
  logic [(L+3)*BD-1:0] in_ref;
  logic [L*BD-1:0]   out_pred;

  int n_vec = 0;
  int n_err = 0;
  int nb    = 0;
  int got   = 0;

  logic [31:0] q[$];
  bit          vin [8] = '{1, 0, 1, 1, 0, 0, 0, 0};

  intra_interp_filter_pipe #(
    .BIT_DEPTH(BD),
    .LANES    (L)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ref   (in_ref),
    .in_phase (in_phase),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pred (out_pred)
  );

  always #5 clk = ~clk;

  function automatic logic [55:0] r7(
    input int a, b, c, d, e, f, g
  );
    return {8'(g), 8'(f), 8'(e), 8'(d),
            8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [31:0] p4(
    input int a, b, c, d
  );
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic        v,
    input logic [4:0]  ph,
    input logic        m,
    input logic [55:0] r
  );
    in_valid = v;
    in_phase = ph;
    in_mode  = m;
    in_ref   = r;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, '0);
  endtask

  // Single beat into an empty pipe: visible exactly 3 cycles later, once.
  task automatic one(
    input string       tag,
    input logic [4:0]  ph,
    input logic        m,
    input logic [55:0] r,
    input logic [31:0] exp
  );
    drive(1'b1, ph, m, r);
    tick();
    idle();
    chk({tag, "_v1"}, 64'(out_valid), 64'(0));
    tick();
    chk({tag, "_v2"}, 64'(out_valid), 64'(0));
    tick();
    chk({tag, "_v3"}, 64'(out_valid), 64'(1));
    chk({tag, "_pred"}, 64'(out_pred), 64'(exp));
    tick();
    chk({tag, "_v4"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #3;
    chk("rst_ov",   64'(out_valid), 64'(0));
    chk("rst_pred", 64'(out_pred),  64'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_iready", 64'(in_ready), 64'(1));

    one("cub_p0", 5'd0, 1'b0,
        r7(10, 20, 30, 40, 50, 60, 70), p4(20, 30, 40, 50));
    one("gau_p0", 5'd0, 1'b1,
        r7(4, 8, 12, 16, 20, 24, 28), p4(8, 12, 16, 20));
    one("gau_p31", 5'd31, 1'b1,
        r7(4, 8, 12, 16, 20, 24, 28), p4(12, 16, 20, 24));
    one("cub_p8", 5'd8, 1'b0,
        r7(10, 20, 30, 40, 50, 60, 70), p4(23, 33, 43, 53));
    one("cub_p31", 5'd31, 1'b0,
        r7(10, 20, 30, 40, 50, 60, 70), p4(30, 40, 50, 60));
`ifdef INTERP_CLIP_EN
    one("cub_p16", 5'd16, 1'b0,
        r7(0, 255, 255, 0, 0, 255, 255), p4(255, 128, 0, 128));
`else
    one("cub_p16", 5'd16, 1'b0,
        r7(0, 255, 255, 0, 0, 255, 255), p4(31, 128, 224, 128));
`endif

    // Bubbles pass through unchanged, offset by 3 cycles.
    for (int c = 0; c < 8; c++) begin
      drive(vin[c], 5'd0, 1'b0,
            r7(10*c+1, 10*c+2, 10*c+3, 10*c+4,
               10*c+5, 10*c+6, 10*c+7));
      tick();
      if (c >= 2) begin
        chk($sformatf("tp_ov%0d", c),
            64'(out_valid), 64'(vin[c-2]));
        if (vin[c-2])
          chk($sformatf("tp_pred%0d", c), 64'(out_pred),
              64'(p4(10*(c-2)+2, 10*(c-2)+3,
                     10*(c-2)+4, 10*(c-2)+5)));
      end else begin
        chk($sformatf("tp_ov%0d", c),
            64'(out_valid), 64'(0));
      end
    end
    idle();
    repeat (3) tick();

    // Backpressure: downstream stalls during cycles 4..7.
    nb  = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      if (nb < 8)
        drive(1'b1, 5'd0, 1'b0,
              r7(8*nb+3, 8*nb+8, 8*nb+13, 8*nb+18,
                 8*nb+23, 8*nb+28, 8*nb+33));
      else
        idle();
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("bp_extra", 64'(out_valid), 64'(0));
        end else begin
          chk($sformatf("bp_pred%0d_c%0d", got, c),
              64'(out_pred), 64'(q[0]));
        end
        if (out_ready) begin
          if (q.size() != 0) void'(q.pop_front());
          got++;
        end else begin
          chk($sformatf("bp_iready_c%0d", c),
              64'(in_ready), 64'(0));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(p4(8*nb+8, 8*nb+13,
                       8*nb+18, 8*nb+23));
        nb++;
      end
      tick();
    end
    chk("bp_count", 64'(got), 64'(8));
    out_ready = 1'b1;
    idle();
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("bp_drain%0d", c),
          64'(out_valid), 64'(0));
    end

    // Reset with three beats in flight.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd0, 1'b0,
            r7(50+c, 51+c, 52+c, 53+c, 54+c, 55+c, 56+c));
      tick();
    end
    idle();
    chk("mid_ov_pre",   64'(out_valid), 64'(1));
    chk("mid_pred_pre", 64'(out_pred),
        64'(p4(51, 52, 53, 54)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_ov_rst",   64'(out_valid), 64'(0));
    chk("mid_pred_rst", 64'(out_pred),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_iready", 64'(in_ready), 64'(1));
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("mid_stale%0d", c),
          64'(out_valid), 64'(0));
    end
    one("post_rst", 5'd0, 1'b0,
        r7(1, 2, 3, 4, 5, 6, 7), p4(2, 3, 4, 5));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
